// File: rtl/ifetch_queue_if.sv
// Instruction-memory request/acknowledge bus between the fetch queue and memory.
// The fetch queue is the master: it raises mem_req with mem_addr and holds both
// until the memory answers with mem_ack and mem_rdata.
interface ifetch_queue_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction-fetch queue feeding the IF/ID register.
// Fetches sequential words over the req/ack bus and buffers up to DEPTH of them,
// each tagged with PC+4. A redirect flushes the buffer. A request that is
// already in flight is still completed on the bus and its data is thrown away.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    ifetch_queue_if.master               mem,
    input  logic                         redirect,
    input  logic [31:0]                  redirect_pc,
    input  logic                         deq,
    output logic                         inst_valid,
    output logic [31:0]                  inst,
    output logic [31:0]                  inst_pc4,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_CX = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e         state_r;
    logic [31:0]    fpc_r;          // next fetch address; holds the in-flight address while dropping
    logic [31:0]    fpc_target_r;   // where to resume once the dropped request completes
    logic           req_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [PW-1:0]  wr_ptr_r;
    logic [CW-1:0]  count_r;
    logic [31:0]    word_mem_r [DEPTH];
    logic [31:0]    pc4_mem_r  [DEPTH];

    logic           pop_s;
    logic           push_s;
    logic           full_s;
    logic           room_s;
    logic [CW:0]    next_cnt_s;

    // Queue bookkeeping: pop/push qualification and next-cycle occupancy
    always_comb begin
        inst_valid = (count_r != {CW{1'b0}});
        full_s     = (count_r == DEPTH_C);
        pop_s      = deq & inst_valid & ~redirect;
        push_s     = (state_r == ST_REQ) & mem.mem_ack & ~redirect;
        next_cnt_s = {1'b0, count_r} + {{CW{1'b0}}, push_s} - {{CW{1'b0}}, pop_s};
        room_s     = (next_cnt_s < DEPTH_CX);
    end

    // Fetch control FSM; mem_req is registered together with the state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            fpc_r        <= RESET_PC;
            fpc_target_r <= RESET_PC;
            req_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (redirect) begin
                        fpc_r <= redirect_pc;
                    end else if (!full_s || pop_s) begin
                        state_r <= ST_REQ;
                        req_r   <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (mem.mem_ack) begin
                        if (redirect) begin
                            fpc_r   <= redirect_pc;
                            state_r <= ST_IDLE;
                            req_r   <= 1'b0;
                        end else begin
                            fpc_r <= fpc_r + 32'd4;
                            if (!room_s) begin
                                state_r <= ST_IDLE;
                                req_r   <= 1'b0;
                            end else begin
                                state_r <= ST_REQ;
                            end
                        end
                    end else if (redirect) begin
                        fpc_target_r <= redirect_pc;
                        state_r      <= ST_DROP;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (mem.mem_ack) begin
                        fpc_r   <= redirect ? redirect_pc : fpc_target_r;
                        state_r <= ST_IDLE;
                        req_r   <= 1'b0;
                    end else if (redirect) begin
                        fpc_target_r <= redirect_pc;
                    end else begin
                        state_r <= ST_DROP;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

    // Pointers and occupancy; a redirect empties the queue by snapping rd to wr
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (redirect) begin
            rd_ptr_r <= wr_ptr_r;
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= next_cnt_s[CW-1:0];
        end
    end

    // Entry storage; contents are meaningful only between rd and wr, so no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            word_mem_r[wr_ptr_r] <= mem.mem_rdata;
            pc4_mem_r[wr_ptr_r]  <= fpc_r + 32'd4;
        end
    end

    assign mem.mem_req  = req_r;
    assign mem.mem_addr = fpc_r;
    assign count        = count_r;
    assign inst         = inst_valid ? word_mem_r[rd_ptr_r] : 32'h0000_0000;
    assign inst_pc4     = inst_valid ? pc4_mem_r[rd_ptr_r]  : 32'h0000_0000;

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized scoreboard bench for ifetch_queue. The reference model describes
// the expected instruction stream: words at sequential addresses from the last
// redirect target, with a request that was outstanding at the redirect dropped.
module tb_ifetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CW       = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          redirect = 1'b0;
    logic [31:0]   redirect_pc = 32'h0;
    logic          deq = 1'b0;
    logic          inst_valid;
    logic [31:0]   inst;
    logic [31:0]   inst_pc4;
    logic [CW-1:0] count;

    ifetch_queue_if bus ();

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem         (bus),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .deq         (deq),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc4    (inst_pc4),
        .count       (count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model
    logic [63:0] exp_q[$];          // {word, pc4} expected at the head, in order
    logic [31:0] nf = RESET_PC;     // next address the model expects to be fetched
    bit          drop_pending = 1'b0;

    // memory model and stimulus knobs
    bit          waiting = 1'b0;
    int          wcnt = 0;
    int          lat = 0;
    int          lat_min = 0;
    int          lat_max = 0;
    int          deq_pct = 0;
    int          redir_pct = 0;
    bit          prev_pending = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: check occupancy, drive inputs, update the model
    task automatic cycle();
        bit ack;
        bit do_redir;
        @(negedge clk);
        check(count == CW'(exp_q.size()), "count", 32'(count), 32'(exp_q.size()));
        check(inst_valid == (exp_q.size() != 0), "inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
        if (prev_pending)
            check(bus.mem_req && bus.mem_addr == prev_addr, "req_hold", bus.mem_addr, prev_addr);
        ack = 1'b0;
        if (bus.mem_req) begin
            if (!waiting) begin
                waiting = 1'b1;
                wcnt    = 0;
                lat     = int'($urandom_range(lat_max, lat_min));
            end
            ack = (wcnt == lat);
            if (ack) waiting = 1'b0;
            else wcnt++;
        end
        do_redir      = ($urandom_range(99, 0) < redir_pct);
        bus.mem_ack   = ack;
        bus.mem_rdata = ack ? mem_word(bus.mem_addr) : $urandom();
        redirect      = do_redir;
        redirect_pc   = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(255, 0)) << 2);
        deq           = ($urandom_range(99, 0) < deq_pct);
        prev_pending  = bus.mem_req & !ack;
        prev_addr     = bus.mem_addr;
        if (do_redir) begin
            exp_q.delete();
            nf           = redirect_pc;
            drop_pending = bus.mem_req & !ack;
        end else if (bus.mem_req && ack) begin
            if (drop_pending) begin
                drop_pending = 1'b0;
            end else begin
                check(bus.mem_addr == nf, "fetch_addr", bus.mem_addr, nf);
                exp_q.push_back({mem_word(nf), nf + 32'd4});
                nf = nf + 32'd4;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Monitor: compare the head whenever the IF/ID register takes it
    initial begin : monitor
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                if (!inst_valid) begin
                    check(inst == 32'h0 && inst_pc4 == 32'h0, "empty_nop", inst, 32'h0);
                end else if (deq && !redirect) begin
                    check(exp_q.size() != 0, "pop_unexpected", inst, 32'h0);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check(inst == e[63:32], "inst", inst, e[63:32]);
                        check(inst_pc4 == e[31:0], "inst_pc4", inst_pc4, e[31:0]);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        bit found;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        check(bus.mem_req == 1'b0 && count == '0, "reset_state", 32'(bus.mem_req), 32'h0);
        check(bus.mem_addr == RESET_PC, "reset_addr", bus.mem_addr, RESET_PC);
        rst = 1'b1;

        // zero-wait memory, no dequeue: four back-to-back fetches fill the queue
        lat_min = 0; lat_max = 0; deq_pct = 0; redir_pct = 0;
        cycle();
        check(bus.mem_req == 1'b1, "req_after_release", 32'(bus.mem_req), 32'h1);
        run(10);
        check(bus.mem_req == 1'b0, "req_idle_full", 32'(bus.mem_req), 32'h0);
        check(count == CW'(DEPTH), "full_count", 32'(count), 32'(DEPTH));
        check(inst == mem_word(RESET_PC), "head_word", inst, mem_word(RESET_PC));
        check(inst_pc4 == RESET_PC + 32'd4, "head_pc4", inst_pc4, RESET_PC + 32'd4);

        // single dequeue from full: occupancy dips and is refilled
        deq_pct = 100; cycle();
        deq_pct = 0;   run(8);

        // three-cycle memory latency with steady dequeue
        lat_min = 2; lat_max = 2; deq_pct = 100;
        run(60);

        // random mix of latency, dequeue and redirects
        lat_min = 0; lat_max = 3; deq_pct = 50; redir_pct = 10;
        run(2000);

        // reset in the middle of an outstanding request
        lat_min = 6; lat_max = 6; deq_pct = 0; redir_pct = 0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            found = prev_pending;
        end
        check(found, "pending_req_seen", 32'(found), 32'h1);
        #3;
        rst = 1'b0;
        #1;
        check(bus.mem_req == 1'b0, "async_reset_req", 32'(bus.mem_req), 32'h0);
        check(count == '0 && !inst_valid, "async_reset_count", 32'(count), 32'h0);
        bus.mem_ack = 1'b0; deq = 1'b0; redirect = 1'b0;
        exp_q.delete();
        nf = RESET_PC; drop_pending = 1'b0; waiting = 1'b0; prev_pending = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        lat_min = 0; lat_max = 3; deq_pct = 60; redir_pct = 8;
        run(2000);

        // drain to full with no redirects: fetch must keep making progress
        lat_min = 0; lat_max = 1; deq_pct = 0; redir_pct = 0;
        run(30);
        check(count == CW'(DEPTH), "final_full", 32'(count), 32'(DEPTH));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
